// File: rtl/llc_snoop_responder.sv
// llc_snoop_responder: LLC bus snoop responder (lookup, result, 8-beat writeback, MESI update); optional LLC_SNOOP_ERR_EN adds proto_err
module llc_snoop_responder #(
    parameter int ADDR_W      = 32,
    parameter int INDEX       = 14,
    parameter int BYTE_OFFSET = 6,
    parameter int TAGS        = ADDR_W - INDEX - BYTE_OFFSET,
    parameter int WAY_W       = 4,
    parameter int BEAT_W      = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snp_valid,
    output logic              snp_ready,
    input  logic [1:0]        snp_op,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              lk_req,
    output logic [INDEX-1:0]  lk_index,
    output logic [TAGS-1:0]   lk_tag,
    input  logic              lk_ack,
    input  logic              lk_hit,
    input  logic [WAY_W-1:0]  lk_way,
    input  logic [1:0]        lk_state,
    output logic              snp_res_valid,
    output logic [1:0]        snp_res,
    output logic              dr_en,
    output logic [INDEX-1:0]  dr_index,
    output logic [WAY_W-1:0]  dr_way,
    output logic [2:0]        dr_beat,
    input  logic [BEAT_W-1:0] dr_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [BEAT_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_last,
    output logic              upd_valid,
    output logic [INDEX-1:0]  upd_index,
    output logic [WAY_W-1:0]  upd_way,
    output logic [1:0]        upd_state
`ifdef LLC_SNOOP_ERR_EN
    ,output logic             proto_err
`endif
);
    localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_INV = 2'b10, OP_RWIM = 2'b11;
    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;
    localparam logic [1:0] R_NOHIT = 2'b00, R_HIT = 2'b01, R_HITM = 2'b10;
    typedef enum logic [2:0] {IDLE, LOOKUP, RESPOND, WB_RD, WB_SEND, UPDATE} state_e;
    state_e            state_q, state_d;
    logic [1:0]        op_q, mesi_q, res;
    logic [TAGS-1:0]   tag_q;
    logic [INDEX-1:0]  index_q;
    logic [WAY_W-1:0]  way_q;
    logic [2:0]        beat_q;
    logic [BEAT_W-1:0] data_q;
    logic              hold_q, ready_q, wb_need, upd_need, unused_offset;
    assign unused_offset = ^snp_addr[BYTE_OFFSET-1:0];
    // snoop outcome from captured op and effective (miss-folded) MESI state
    always_comb begin
        res      = (op_q == OP_RD || op_q == OP_RWIM) ? (mesi_q == ST_I ? R_NOHIT : mesi_q == ST_M ? R_HITM : R_HIT) :
                   (op_q == OP_INV && mesi_q == ST_S) ? R_HIT : R_NOHIT;
        wb_need  = mesi_q == ST_M && (op_q == OP_RD || op_q == OP_RWIM);
        upd_need = op_q == OP_RD   ? (mesi_q == ST_E || mesi_q == ST_M) :
                   op_q == OP_INV  ? mesi_q == ST_S :
                   op_q == OP_RWIM ? mesi_q != ST_I : 1'b0;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = snp_valid ? LOOKUP : IDLE;
            LOOKUP:  state_d = lk_ack ? RESPOND : LOOKUP;
            RESPOND: state_d = wb_need ? WB_RD : upd_need ? UPDATE : IDLE;
            WB_RD:   state_d = WB_SEND;
            WB_SEND: state_d = !wb_ready ? WB_SEND : beat_q == 3'd7 ? UPDATE : WB_RD;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // captured op fields, lookup result, beat counter and held writeback beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            tag_q   <= '0;
            index_q <= '0;
            way_q   <= '0;
            mesi_q  <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            hold_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            if (state_q == IDLE && snp_valid) begin
                op_q    <= snp_op;
                tag_q   <= snp_addr[ADDR_W-1 -: TAGS];
                index_q <= snp_addr[BYTE_OFFSET +: INDEX];
            end
            if (state_q == LOOKUP && lk_ack) begin
                way_q  <= lk_way;
                mesi_q <= lk_hit ? lk_state : ST_I;
            end
            if (state_q == WB_SEND && wb_ready) beat_q <= beat_q + 3'd1;
            if (state_q == WB_SEND && !hold_q) data_q <= dr_data;
            hold_q  <= state_q == WB_SEND && !wb_ready;
            ready_q <= state_d == IDLE;
        end
    end
    // outputs decoded from state; first send cycle forwards dr_data, stalls replay the held copy
    always_comb begin
        snp_ready     = ready_q;
        lk_req        = state_q == LOOKUP;
        lk_index      = index_q;
        lk_tag        = tag_q;
        snp_res_valid = state_q == RESPOND;
        snp_res       = snp_res_valid ? res : R_NOHIT;
        dr_en         = state_q == WB_RD;
        dr_index      = index_q;
        dr_way        = way_q;
        dr_beat       = beat_q;
        wb_valid      = state_q == WB_SEND;
        wb_data       = !wb_valid ? '0 : hold_q ? data_q : dr_data;
        wb_addr       = {tag_q, index_q, {BYTE_OFFSET{1'b0}}};
        wb_last       = wb_valid && beat_q == 3'd7;
        upd_valid     = state_q == UPDATE;
        upd_index     = index_q;
        upd_way       = way_q;
        upd_state     = (upd_valid && op_q == OP_RD) ? ST_S : ST_I;
`ifdef LLC_SNOOP_ERR_EN
        proto_err     = snp_res_valid && mesi_q != ST_I &&
                        ((op_q == OP_INV && mesi_q != ST_S) || op_q == OP_WR);
`endif
    end
endmodule

// File: tb/tb_llc_snoop_responder.sv
// tb_llc_snoop_responder: directed self-checking bench for llc_snoop_responder
module tb_llc_snoop_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snp_valid = 1'b0, snp_ready;
    logic [1:0]  snp_op = 2'b00;
    logic [31:0] snp_addr = '0;
    logic        lk_req, lk_ack = 1'b0, lk_hit = 1'b0;
    logic [13:0] lk_index, dr_index, upd_index;
    logic [11:0] lk_tag;
    logic [3:0]  lk_way = '0, dr_way, upd_way;
    logic [1:0]  lk_state = '0, snp_res, upd_state;
    logic        snp_res_valid, dr_en, wb_valid, wb_ready = 1'b1, wb_last, upd_valid;
    logic [2:0]  dr_beat;
    logic [63:0] dr_data = '0, wb_data;
    logic [31:0] wb_addr;
`ifdef LLC_SNOOP_ERR_EN
    logic        proto_err;
`endif
    int n_chk = 0, n_fail = 0;

    llc_snoop_responder dut (
        .clk(clk), .rst_n(rst_n), .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op),
        .snp_addr(snp_addr), .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag), .lk_ack(lk_ack),
        .lk_hit(lk_hit), .lk_way(lk_way), .lk_state(lk_state), .snp_res_valid(snp_res_valid),
        .snp_res(snp_res), .dr_en(dr_en), .dr_index(dr_index), .dr_way(dr_way), .dr_beat(dr_beat),
        .dr_data(dr_data), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_addr(wb_addr), .wb_last(wb_last), .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_way(upd_way), .upd_state(upd_state)
`ifdef LLC_SNOOP_ERR_EN
        , .proto_err(proto_err)
`endif
    );

    always #5 clk = ~clk;

    // data array model: one-cycle read latency, garbage when not reading
    function automatic logic [63:0] beat_val(input logic [3:0] w, input logic [2:0] b);
        return {40'hBEEF000000, 4'h0, w, 13'h0, b};
    endfunction
    always @(posedge clk) dr_data <= dr_en ? beat_val(dr_way, dr_beat) : 64'hDEAD_DEAD_DEAD_DEAD;

    task automatic issue(input logic [1:0] op, input logic [31:0] addr);
        @(negedge clk);
        snp_valid = 1'b1; snp_op = op; snp_addr = addr;
        @(negedge clk);
        snp_valid = 1'b0; snp_addr = 32'hFFFF_FFFF;
    endtask

    task automatic ack(input logic hit, input logic [3:0] way, input logic [1:0] st);
        lk_ack = 1'b1; lk_hit = hit; lk_way = way; lk_state = st;
        @(negedge clk);
        lk_ack = 1'b0; lk_hit = 1'b0; lk_state = 2'b00;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_chk++; if ({snp_ready, lk_req, snp_res_valid, dr_en, wb_valid, upd_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 000000", {snp_ready, lk_req, snp_res_valid, dr_en, wb_valid, upd_valid}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (snp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", snp_ready); end
        // lk_ack while idle must not start anything
        lk_ack = 1'b1; lk_hit = 1'b1; lk_state = 2'b11;
        @(negedge clk); lk_ack = 1'b0; lk_hit = 1'b0; lk_state = 2'b00;
        @(negedge clk);
        n_chk++; if ({snp_ready, snp_res_valid, lk_req} !== 3'b100) begin
            n_fail++; $display("FAIL idle_ack_ignored: got %b want 100", {snp_ready, snp_res_valid, lk_req}); end
    endtask

    task automatic test_read_s;
        issue(2'b00, 32'h1234_5678);
        n_chk++; if ({lk_req, snp_ready, lk_index, lk_tag} !== {1'b1, 1'b0, 14'h1159, 12'h123}) begin
            n_fail++; $display("FAIL read_s_lookup: got req=%b rdy=%b idx=%h tag=%h want 1 0 1159 123", lk_req, snp_ready, lk_index, lk_tag); end
        @(negedge clk);
        n_chk++; if ({lk_req, lk_index} !== {1'b1, 14'h1159}) begin
            n_fail++; $display("FAIL read_s_hold: got req=%b idx=%h want 1 1159", lk_req, lk_index); end
        ack(1'b1, 4'd3, 2'b01);
        n_chk++; if ({snp_res_valid, snp_res, lk_req, dr_en, upd_valid} !== 6'b101000) begin
            n_fail++; $display("FAIL read_s_respond: got %b want 101000", {snp_res_valid, snp_res, lk_req, dr_en, upd_valid}); end
        @(negedge clk);
        n_chk++; if ({snp_ready, upd_valid, dr_en, snp_res_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL read_s_idle: got %b want 1000", {snp_ready, upd_valid, dr_en, snp_res_valid}); end
    endtask

    task automatic test_read_m_wb;
        int errs = 0;
        wb_ready = 1'b1;
        issue(2'b00, 32'h1234_5678);
        ack(1'b1, 4'd5, 2'b11);
        n_chk++; if ({snp_res_valid, snp_res} !== 3'b110) begin
            n_fail++; $display("FAIL read_m_res: got %b want 110", {snp_res_valid, snp_res}); end
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            if ({dr_en, dr_beat, dr_way, dr_index, wb_valid} !== {1'b1, 3'(b), 4'd5, 14'h1159, 1'b0}) begin
                errs++; $display("FAIL read_m_rd beat %0d: got en=%b beat=%0d way=%0d idx=%h wbv=%b", b, dr_en, dr_beat, dr_way, dr_index, wb_valid); end
            @(negedge clk);
            if ({wb_valid, dr_en, wb_last, wb_data, wb_addr} !== {1'b1, 1'b0, b == 7, beat_val(4'd5, 3'(b)), 32'h1234_5640}) begin
                errs++; $display("FAIL read_m_send beat %0d: got v=%b en=%b last=%b data=%h addr=%h want data=%h addr=12345640",
                                 b, wb_valid, dr_en, wb_last, wb_data, wb_addr, beat_val(4'd5, 3'(b))); end
        end
        n_chk++; if (errs != 0) n_fail++;
        @(negedge clk);
        n_chk++; if ({upd_valid, upd_way, upd_index, upd_state, wb_valid} !== {1'b1, 4'd5, 14'h1159, 2'b01, 1'b0}) begin
            n_fail++; $display("FAIL read_m_upd: got v=%b way=%0d idx=%h st=%b want 1 5 1159 01", upd_valid, upd_way, upd_index, upd_state); end
        @(negedge clk);
        n_chk++; if ({snp_ready, upd_valid} !== 2'b10) begin
            n_fail++; $display("FAIL read_m_idle: got %b want 10", {snp_ready, upd_valid}); end
    endtask

    task automatic test_rwim_stall;
        int errs = 0;
        wb_ready = 1'b1;
        issue(2'b11, 32'h00AB_CDC0);
        ack(1'b1, 4'd2, 2'b11);
        n_chk++; if (snp_res !== 2'b10) begin n_fail++; $display("FAIL rwim_m_res: got %b want 10", snp_res); end
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            if (b == 2) wb_ready = 1'b0;
            @(negedge clk);
            if ({wb_valid, wb_data} !== {1'b1, beat_val(4'd2, 3'(b))}) begin
                errs++; $display("FAIL rwim_send beat %0d: got v=%b data=%h want data=%h", b, wb_valid, wb_data, beat_val(4'd2, 3'(b))); end
            if (b == 2) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    n_chk++; if ({wb_valid, dr_en, wb_data} !== {1'b1, 1'b0, beat_val(4'd2, 3'd2)}) begin
                        n_fail++; $display("FAIL rwim_stall cycle %0d: got v=%b en=%b data=%h", s, wb_valid, dr_en, wb_data); end
                end
                wb_ready = 1'b1;
            end
        end
        n_chk++; if (errs != 0) n_fail++;
        @(negedge clk);
        n_chk++; if ({upd_valid, upd_way, upd_state, upd_index} !== {1'b1, 4'd2, 2'b00, 14'h2F37}) begin
            n_fail++; $display("FAIL rwim_upd: got v=%b way=%0d st=%b idx=%h want 1 2 00 2f37", upd_valid, upd_way, upd_state, upd_index); end
        @(negedge clk);
    endtask

    task automatic test_inv_e;
        issue(2'b10, 32'h0000_1040);
        ack(1'b1, 4'd9, 2'b10);
        n_chk++; if ({snp_res_valid, snp_res} !== 3'b100) begin
            n_fail++; $display("FAIL inv_e_res: got %b want 100", {snp_res_valid, snp_res}); end
`ifdef LLC_SNOOP_ERR_EN
        n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL inv_e_err: got %b want 1", proto_err); end
`endif
        @(negedge clk);
        n_chk++; if ({snp_ready, upd_valid, dr_en} !== 3'b100) begin
            n_fail++; $display("FAIL inv_e_noupd: got %b want 100", {snp_ready, upd_valid, dr_en}); end
`ifdef LLC_SNOOP_ERR_EN
        n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL inv_e_err_pulse: got %b want 0", proto_err); end
`endif
    endtask

    task automatic test_inv_s_write_m;
        issue(2'b10, 32'hFFFF_FFC0);
        ack(1'b1, 4'd15, 2'b01);
        n_chk++; if (snp_res !== 2'b01) begin n_fail++; $display("FAIL inv_s_res: got %b want 01", snp_res); end
`ifdef LLC_SNOOP_ERR_EN
        n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL inv_s_err: got %b want 0", proto_err); end
`endif
        @(negedge clk);
        n_chk++; if ({upd_valid, upd_way, upd_state, upd_index} !== {1'b1, 4'd15, 2'b00, 14'h3FFF}) begin
            n_fail++; $display("FAIL inv_s_upd: got v=%b way=%0d st=%b idx=%h want 1 15 00 3fff", upd_valid, upd_way, upd_state, upd_index); end
        issue(2'b01, 32'h1234_5678);
        ack(1'b1, 4'd1, 2'b11);
        n_chk++; if ({snp_res_valid, snp_res} !== 3'b100) begin
            n_fail++; $display("FAIL write_m_res: got %b want 100", {snp_res_valid, snp_res}); end
`ifdef LLC_SNOOP_ERR_EN
        n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL write_m_err: got %b want 1", proto_err); end
`endif
        @(negedge clk);
        n_chk++; if ({snp_ready, dr_en, upd_valid} !== 3'b100) begin
            n_fail++; $display("FAIL write_m_idle: got %b want 100", {snp_ready, dr_en, upd_valid}); end
    endtask

    task automatic test_rwim_miss;
        issue(2'b11, 32'h0BAD_0000);
        ack(1'b0, 4'd4, 2'b11);
        n_chk++; if ({snp_res_valid, snp_res} !== 3'b100) begin
            n_fail++; $display("FAIL rwim_miss_res: got %b want 100", {snp_res_valid, snp_res}); end
        @(negedge clk);
        n_chk++; if ({snp_ready, dr_en, upd_valid, wb_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL rwim_miss_idle: got %b want 1000", {snp_ready, dr_en, upd_valid, wb_valid}); end
    endtask

    task automatic test_reset_mid_wb;
        int seen = 0;
        wb_ready = 1'b1;
        issue(2'b00, 32'h1234_5678);
        ack(1'b1, 4'd7, 2'b11);
        for (int b = 0; b < 4; b++) begin @(negedge clk); @(negedge clk); end
        @(negedge clk); wb_ready = 1'b0;
        @(negedge clk);
        n_chk++; if ({wb_valid, wb_data} !== {1'b1, beat_val(4'd7, 3'd4)}) begin
            n_fail++; $display("FAIL rst_mid_pre: got v=%b data=%h want 1 %h", wb_valid, wb_data, beat_val(4'd7, 3'd4)); end
        rst_n = 1'b0;
        #1;
        n_chk++; if ({snp_ready, lk_req, snp_res_valid, dr_en, wb_valid, wb_last, upd_valid, upd_state} !== 9'b0 ||
                     {wb_data, wb_addr, lk_index, lk_tag, dr_beat, dr_way} !== '0) begin
            n_fail++; $display("FAIL rst_mid_zero: got ctl=%b data=%h addr=%h idx=%h", {snp_ready, lk_req, snp_res_valid, dr_en, wb_valid, wb_last, upd_valid, upd_state}, wb_data, wb_addr, lk_index); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; wb_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (upd_valid || wb_valid || dr_en) seen++;
        end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_after: got %0d active cycles want 0", seen); end
        n_chk++; if (snp_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", snp_ready); end
        issue(2'b00, 32'h0000_0080);
        ack(1'b1, 4'd6, 2'b10);
        n_chk++; if (snp_res !== 2'b01) begin n_fail++; $display("FAIL rst_mid_next_res: got %b want 01", snp_res); end
        @(negedge clk);
        n_chk++; if ({upd_valid, upd_way, upd_state, upd_index} !== {1'b1, 4'd6, 2'b01, 14'h0002}) begin
            n_fail++; $display("FAIL rst_mid_next_upd: got v=%b way=%0d st=%b idx=%h want 1 6 01 0002", upd_valid, upd_way, upd_state, upd_index); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_read_s;
        test_read_m_wb;
        test_rwim_stall;
        test_inv_e;
        test_inv_s_write_m;
        test_rwim_miss;
        test_reset_mid_wb;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/llc_snoop_responder.md
Name: llc_snoop_responder

Overview:
- Bus-side snoop responder for the 16 MB, 16-way, 64 B-line LLC. This is the receiving end of the bus operations the LLC issues.
- Accepts snooped ops from other caches and looks up the tag/MESI array through a request/ack port.
- Returns a snoop result (NOHIT/HIT/HITM), writes back modified lines as 8 x 64-bit beats, then issues a MESI state update.

Parameters:
- ADDR_W, 32, physical address width
- INDEX, 14, set index bits (16384 sets)
- BYTE_OFFSET, 6, line offset bits (64 B line)
- TAGS, 12, tag bits = ADDR_W-INDEX-BYTE_OFFSET
- WAY_W, 4, way select width (16 ways)
- BEAT_W, 64, writeback beat width; beats per line = 512/BEAT_W = 8

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- snp_valid  in  1  snooped op present
- snp_ready  out  1  responder can accept op
- snp_op  in  2  00 READ, 01 WRITE, 10 INVALIDATE, 11 RWIM
- snp_addr  in  ADDR_W  snooped address
- lk_req  out  1  tag lookup request
- lk_index  out  INDEX  lookup set
- lk_tag  out  TAGS  lookup tag
- lk_ack  in  1  lookup complete (one-cycle pulse)
- lk_hit  in  1  tag match, valid at lk_ack
- lk_way  in  WAY_W  matching way, valid at lk_ack
- lk_state  in  2  MESI: 00 I, 01 S, 10 E, 11 M; valid at lk_ack
- snp_res_valid  out  1  snoop result strobe
- snp_res  out  2  00 NOHIT, 01 HIT, 10 HITM
- dr_en  out  1  data array read enable
- dr_index  out  INDEX  read set
- dr_way  out  WAY_W  read way
- dr_beat  out  3  beat number
- dr_data  in  BEAT_W  read data, valid cycle after dr_en
- wb_valid  out  1  writeback beat valid
- wb_ready  in  1  bus accepts beat
- wb_data  out  BEAT_W  beat data
- wb_addr  out  ADDR_W  {tag,index,6'b0}, stable during writeback
- wb_last  out  1  beat 7
- upd_valid  out  1  state update strobe
- upd_index  out  INDEX  update set
- upd_way  out  WAY_W  update way
- upd_state  out  2  new MESI state

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; beat counter 0.
  - All outputs 0, except snp_ready=1 once out of reset.
  - In-flight op is dropped with no update or result.
- Address decode: tag=addr[31:20], index=addr[19:6], offset ignored. Fields are registered on accept.
- IDLE:
  - snp_ready=1.
  - On snp_valid&&snp_ready: capture op and address, go LOOKUP.
- LOOKUP:
  - lk_req held high with stable lk_index/lk_tag until lk_ack; lk_req drops the cycle after ack.
  - lk_hit=0 is treated as state I.
  - Go RESPOND.
- RESPOND: one cycle with snp_res_valid=1. Result and next state:
  - READ: I -> NOHIT, no update. S -> HIT, no update. E -> HIT, new S. M -> HITM, writeback, new S.
  - WRITE: NOHIT, no update, regardless of state.
  - INVALIDATE: I -> NOHIT. S -> HIT, new I. E/M -> NOHIT, no update (protocol violation).
  - RWIM: I -> NOHIT. S/E -> HIT, new I. M -> HITM, writeback, new I.
- Exit from RESPOND:
  - Writeback required: go WB_RD.
  - Else, update required: go UPDATE.
  - Else: go IDLE.
- WB_RD: dr_en=1 for one cycle with dr_index, dr_way=captured lk_way, dr_beat=counter. Next cycle go WB_SEND.
- WB_SEND:
  - Capture dr_data into wb_data on entry; wb_valid=1, data held stable until wb_ready.
  - On accept, beat < 7: counter+1, go WB_RD.
  - On accept, beat = 7 (wb_last=1): go UPDATE.
  - Minimum 2 cycles per beat.
- UPDATE: upd_valid=1 for one cycle with upd_index, upd_way, upd_state; then IDLE.
- One op in flight; snp_ready=0 outside IDLE.
- lk_ack outside LOOKUP is ignored.

Optional Feature:
- Macro: LLC_SNOOP_ERR_EN.
- Defined:
  - Adds output port proto_err (1 bit).
  - proto_err pulses high for the RESPOND cycle on INVALIDATE hitting E or M.
  - proto_err also pulses for WRITE hitting any non-I state.
- Undefined: port absent; responses identical.

Test Plan:
- READ 0x1234_5678, ack lk_hit=1, way 3, S -> lk_index=0x1159, lk_tag=0x123; snp_res=HIT; no dr_en, no upd_valid; snp_ready back in 1 cycle.
- READ 0x1234_5678, ack way 5, M, wb_ready=1 -> snp_res=HITM; 8 beats dr_beat 0..7 in order; wb_addr=0x1234_5640; wb_last on beat 7 only; then upd_valid, way 5, state S.
- RWIM, M, wb_ready low 3 cycles on beat 2 -> wb_data and wb_valid held stable; no dr_en during the stall; final upd_state=I.
- INVALIDATE, E -> NOHIT; no update; proto_err=1 with LLC_SNOOP_ERR_EN, absent without.
- RWIM, lk_hit=0 -> NOHIT; no writeback, no update.
- rst_n low during WB_SEND beat 4 -> all outputs 0 immediately; no upd_valid after release; next op handled normally.
